// File: rtl/video_in_pkg.sv
// Shared constants and FSM state type for the video-in capture path
// (burst writer and its companion FIFO).
package video_in_pkg;

   localparam int unsigned DATA_SIZE   = 32;
   localparam int unsigned NB_PACK     = 16;
   localparam int unsigned FRAME_WORDS = 76800;

   typedef enum logic [1:0] {
      StIdle,
      StWait1,
      StWait2,
      StWrite
   } wr_state_e;

   // Byte address of a 32-bit word within a frame.
   function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
      return base + (idx << 2);
   endfunction

endpackage

// File: rtl/wb_burst_writer_if.sv
// Wishbone classic write-master bus bundle for the burst writer.
interface wb_burst_writer_if #(
   parameter int unsigned DATA_SIZE = 32
) ();

   logic                 wb_cyc_o;
   logic                 wb_stb_o;
   logic                 wb_we_o;
   logic [31:0]          wb_adr_o;
   logic [DATA_SIZE-1:0] wb_dat_o;
   logic [3:0]           wb_sel_o;
   logic                 wb_ack_i;

   modport master (
      output wb_cyc_o,
      output wb_stb_o,
      output wb_we_o,
      output wb_adr_o,
      output wb_dat_o,
      output wb_sel_o,
      input  wb_ack_i
   );

   modport slave (
      input  wb_cyc_o,
      input  wb_stb_o,
      input  wb_we_o,
      input  wb_adr_o,
      input  wb_dat_o,
      input  wb_sel_o,
      output wb_ack_i
   );

endinterface

// File: rtl/wb_burst_writer.sv
// Drains NB_PACK-word packs from the capture FIFO into a frame buffer over
// Wishbone classic, one single-beat write per word inside a held cycle.
module wb_burst_writer #(
   parameter int unsigned DATA_SIZE   = video_in_pkg::DATA_SIZE,
   parameter int unsigned NB_PACK     = video_in_pkg::NB_PACK,
   parameter int unsigned FRAME_WORDS = video_in_pkg::FRAME_WORDS
) (
   input  logic                 clk,
   input  logic                 nRST,
   input  logic                 en,
   input  logic [31:0]          frame_base,
   input  logic [DATA_SIZE-1:0] fifo_data,
   input  logic                 nb_pack_available,
   output logic                 r_ack,
   output logic                 frame_done,
   wb_burst_writer_if.master    wb
);

   import video_in_pkg::*;

   localparam int unsigned IdxW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
   localparam int unsigned CntW = (NB_PACK > 1) ? $clog2(NB_PACK) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(FRAME_WORDS - 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(NB_PACK - 1);

   wr_state_e            state_q, state_d;
   logic                 cyc_q, cyc_d;
   logic                 stb_q, stb_d;
   logic [3:0]           sel_q, sel_d;
   logic [31:0]          adr_q, adr_d;
   logic [DATA_SIZE-1:0] dat_q, dat_d;
   logic [IdxW-1:0]      idx_q, idx_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [31:0]          base_q, base_d;
   logic                 done_q, done_d;

   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      stb_d   = stb_q;
      sel_d   = sel_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      base_d  = base_q;
      done_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (en && nb_pack_available) begin
               cyc_d   = 1'b1;
               state_d = StWait2;
               // Base is only sampled at a frame boundary so a frame never straddles two buffers.
               if (idx_q == '0) begin
                  base_d = frame_base;
               end
            end
         end
         StWait1: begin
            state_d = StWait2;
         end
         StWait2: begin
            dat_d   = fifo_data;
            adr_d   = word_addr(base_q, 32'(idx_q));
            stb_d   = 1'b1;
            sel_d   = 4'hF;
            state_d = StWrite;
         end
         StWrite: begin
            if (wb.wb_ack_i) begin
               stb_d = 1'b0;
               sel_d = 4'h0;
               if (idx_q == LastIdx) begin
                  idx_d  = '0;
                  done_d = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
               if (cnt_q < LastCnt) begin
                  cnt_d   = cnt_q + 1'b1;
                  state_d = StWait1;
               end else begin
                  cnt_d   = '0;
                  cyc_d   = 1'b0;
                  state_d = StIdle;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state_q <= StIdle;
         cyc_q   <= 1'b0;
         stb_q   <= 1'b0;
         sel_q   <= 4'h0;
         adr_q   <= '0;
         dat_q   <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         base_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         stb_q   <= stb_d;
         sel_q   <= sel_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         base_q  <= base_d;
         done_q  <= done_d;
      end
   end

   // Pop is combinational so the FIFO advances on the very edge that retires the beat.
   assign r_ack       = (state_q == StWrite) && wb.wb_ack_i;
   assign frame_done  = done_q;
   assign wb.wb_cyc_o = cyc_q;
   assign wb.wb_we_o  = cyc_q;
   assign wb.wb_stb_o = stb_q;
   assign wb.wb_sel_o = sel_q;
   assign wb.wb_adr_o = adr_q;
   assign wb.wb_dat_o = dat_q;

endmodule

// File: tb/tb_wb_burst_writer.sv
// Directed bench: FIFO model with registered read data, a Wishbone slave with
// programmable wait states, and a negedge monitor that logs every beat.
module tb_wb_burst_writer;

   logic        clk;
   logic        nRST;
   logic        en;
   logic [31:0] frame_base;
   logic [31:0] fifo_data;
   logic        nb_pack_available;
   logic        r_ack;
   logic        frame_done;

   wb_burst_writer_if #(.DATA_SIZE(32)) wb_if ();

   wb_burst_writer #(
      .DATA_SIZE  (32),
      .NB_PACK    (16),
      .FRAME_WORDS(32)
   ) dut (
      .clk              (clk),
      .nRST             (nRST),
      .en               (en),
      .frame_base       (frame_base),
      .fifo_data        (fifo_data),
      .nb_pack_available(nb_pack_available),
      .r_ack            (r_ack),
      .frame_done       (frame_done),
      .wb               (wb_if.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc_n = 0;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   // FIFO model: registered pointer, registered RAM output
   logic [31:0] mem [256];
   int          wr_ptr;
   int          rd_ptr;

   always @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         rd_ptr    <= 0;
         fifo_data <= '0;
      end else begin
         if (r_ack) rd_ptr <= rd_ptr + 1;
         fifo_data <= mem[rd_ptr % 256];
      end
   end

   assign nb_pack_available = (wr_ptr - rd_ptr) >= 16;

   // Slave: inserts wait_n wait states on the beat with global index wait_idx
   int slave_idx = 0;
   int wcnt      = 0;
   int wait_idx;
   int wait_n;

   assign wb_if.wb_ack_i = wb_if.wb_stb_o && (wcnt >= ((slave_idx == wait_idx) ? wait_n : 0));

   always @(posedge clk) begin
      if (wb_if.wb_stb_o && wb_if.wb_ack_i) begin
         slave_idx <= slave_idx + 1;
         wcnt      <= 0;
      end else if (wb_if.wb_stb_o) begin
         wcnt <= wcnt + 1;
      end
   end

   // Monitor
   logic [31:0] log_adr [256];
   logic [31:0] log_dat [256];
   int          ack_cyc [256];
   int          stb_len [256];
   int ack_cnt  = 0;
   int rack_cnt = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int stb_run  = 0;
   int instab   = 0;
   int cyc_gap  = 0;
   int we_mis   = 0;
   int sel_mis  = 0;
   bit mon_cyc  = 1'b0;
   logic        prev_stb = 1'b0;
   logic [31:0] prev_adr = '0;
   logic [31:0] prev_dat = '0;

   always @(negedge clk) begin
      if (wb_if.wb_stb_o && wb_if.wb_ack_i) begin
         log_adr[ack_cnt] = wb_if.wb_adr_o;
         log_dat[ack_cnt] = wb_if.wb_dat_o;
         ack_cyc[ack_cnt] = cyc_n;
         stb_len[ack_cnt] = stb_run + 1;
         stb_run          = 0;
         ack_cnt++;
      end else if (wb_if.wb_stb_o) begin
         stb_run++;
      end
      if (r_ack) rack_cnt++;
      if (frame_done) begin
         done_cnt++;
         done_cyc = cyc_n;
      end
      if (wb_if.wb_stb_o && prev_stb &&
          (wb_if.wb_adr_o != prev_adr || wb_if.wb_dat_o != prev_dat)) instab++;
      if (mon_cyc && (ack_cnt % 16 != 0) && !wb_if.wb_cyc_o) cyc_gap++;
      if (wb_if.wb_we_o !== wb_if.wb_cyc_o) we_mis++;
      if (wb_if.wb_stb_o && wb_if.wb_sel_o !== 4'hF) sel_mis++;
      prev_stb = wb_if.wb_stb_o;
      prev_adr = wb_if.wb_adr_o;
      prev_dat = wb_if.wb_dat_o;
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic push(input int first, input int count);
      for (int i = 0; i < count; i++) begin
         mem[wr_ptr % 256] = 32'(first + i);
         wr_ptr++;
      end
   endtask

   task automatic wait_acks(input int n, input string tag);
      int b = 0;
      while (ack_cnt < n && b < 2000) begin
         @(negedge clk);
         #1;
         b++;
      end
      chk(tag, 32'(ack_cnt >= n), 32'd1);
   endtask

   initial begin
      int b;
      int base_cnt;
      nRST       = 1'b0;
      en         = 1'b0;
      frame_base = 32'h1000;
      wr_ptr     = 0;
      wait_idx   = -1;
      wait_n     = 0;

      #12;
      chk("rst_cyc", 32'(wb_if.wb_cyc_o), 32'd0);
      chk("rst_stb", 32'(wb_if.wb_stb_o), 32'd0);
      chk("rst_we", 32'(wb_if.wb_we_o), 32'd0);
      chk("rst_sel", 32'(wb_if.wb_sel_o), 32'd0);
      chk("rst_adr", wb_if.wb_adr_o, 32'd0);
      chk("rst_dat", wb_if.wb_dat_o, 32'd0);
      chk("rst_rack_done", {30'd0, r_ack, frame_done}, 32'd0);

      @(negedge clk);
      nRST = 1'b1;
      en   = 1'b1;

      // Fewer than a pack: must stay idle
      push(0, 15);
      repeat (6) @(negedge clk);
      #1;
      chk("idle_underfull", 32'(wb_if.wb_cyc_o), 32'd0);

      // Burst 1: zero-wait slave
      mon_cyc = 1'b1;
      push(15, 1);
      wait_acks(16, "b1_timeout");
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("b1_adr%0d", i), log_adr[i], 32'h1000 + 32'(4 * i));
         chk($sformatf("b1_dat%0d", i), log_dat[i], 32'(i));
      end
      for (int i = 1; i < 16; i++) begin
         chk($sformatf("b1_gap%0d", i), 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
      end
      chk("b1_rack", 32'(rack_cnt), 32'd16);
      chk("b1_cyc_gap", 32'(cyc_gap), 32'd0);
      @(negedge clk);
      #1;
      chk("b1_cyc_end", 32'(wb_if.wb_cyc_o), 32'd0);

      // Burst 2: 5 wait states on word 3, completes the 32-word frame
      wait_idx = 19;
      wait_n   = 5;
      push(16, 16);
      wait_acks(32, "b2_timeout");
      chk("b2_dat3", log_dat[19], 32'd19);
      chk("b2_adr3", log_adr[19], 32'h104C);
      chk("b2_stb_len3", 32'(stb_len[19]), 32'd6);
      chk("b2_stb_len2", 32'(stb_len[18]), 32'd1);
      chk("b2_instab", 32'(instab), 32'd0);
      chk("b2_rack", 32'(rack_cnt), 32'd32);
      chk("b2_last_adr", log_adr[31], 32'h107C);
      repeat (2) @(negedge clk);
      #1;
      chk("b2_done_cnt", 32'(done_cnt), 32'd1);
      chk("b2_done_cyc", 32'(done_cyc - ack_cyc[31]), 32'd1);

      // Burst 3: en dropped after word 7 acked
      push(32, 16);
      wait_acks(40, "b3_w7_timeout");
      en = 1'b0;
      push(48, 16);
      wait_acks(48, "b3_timeout");
      chk("b3_wrap_adr", log_adr[32], 32'h1000);
      chk("b3_adr8", log_adr[40], 32'h1020);
      chk("b3_adr15", log_adr[47], 32'h103C);
      chk("b3_dat15", log_dat[47], 32'd47);
      repeat (20) @(negedge clk);
      #1;
      chk("b3_no_burst_cyc", 32'(wb_if.wb_cyc_o), 32'd0);
      chk("b3_no_burst_acks", 32'(ack_cnt), 32'd48);

      // Burst 4: base changed mid-frame is ignored until the wrap
      frame_base = 32'h2000;
      en         = 1'b1;
      wait_acks(64, "b4_timeout");
      chk("b4_adr0", log_adr[48], 32'h1040);
      chk("b4_adr15", log_adr[63], 32'h107C);
      repeat (2) @(negedge clk);
      #1;
      chk("b4_done_cnt", 32'(done_cnt), 32'd2);
      push(64, 16);
      wait_acks(80, "b5_timeout");
      chk("b5_adr0", log_adr[64], 32'h2000);
      chk("b5_dat0", log_dat[64], 32'd64);

      // Reset while in WRITE
      push(80, 16);
      frame_base = 32'h5000;
      wait_acks(82, "b6_timeout");
      b = 0;
      while (!wb_if.wb_stb_o && b < 50) begin
         @(posedge clk);
         #1;
         b++;
      end
      chk("b6_in_write", 32'(wb_if.wb_stb_o), 32'd1);
      #1;
      mon_cyc = 1'b0;
      nRST    = 1'b0;
      #1;
      chk("rst_mid_cyc", 32'(wb_if.wb_cyc_o), 32'd0);
      chk("rst_mid_stb", 32'(wb_if.wb_stb_o), 32'd0);
      chk("rst_mid_rack", 32'(r_ack), 32'd0);
      chk("rst_mid_adr", wb_if.wb_adr_o, 32'd0);
      wr_ptr = 0;
      @(negedge clk);
      nRST = 1'b1;
      base_cnt = ack_cnt;
      push(100, 16);
      wait_acks(base_cnt + 1, "post_rst_timeout");
      chk("post_rst_adr", log_adr[base_cnt], 32'h5000);
      chk("post_rst_dat", log_dat[base_cnt], 32'd100);
      wait_acks(base_cnt + 16, "post_rst_burst_timeout");
      chk("post_rst_adr15", log_adr[base_cnt + 15], 32'h503C);

      chk("we_eq_cyc", 32'(we_mis), 32'd0);
      chk("sel_on_stb", 32'(sel_mis), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/wb_burst_writer.md
WB_BURST_WRITER -- requirements
Module: wb_burst_writer

Interface
REQ-001 Parameter DATA_SIZE, default 32: FIFO word and Wishbone data width.
REQ-002 Parameter NB_PACK, default 16: words per burst; equals the FIFO pack threshold.
REQ-003 Parameter FRAME_WORDS, default 76800: 32-bit words per video frame (640x480 8-bit pixels, 4 per word).
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 nRST  in  1  reset, asynchronous, active-low.
REQ-006 en  in  1  level; permits new bursts.
REQ-007 frame_base  in  32  byte address of frame start.
REQ-008 fifo_data  in  DATA_SIZE  FIFO read data; registered RAM output.
REQ-009 nb_pack_available  in  1  FIFO holds >= NB_PACK words.
REQ-010 r_ack  out  1  one-cycle pop of the FIFO head word.
REQ-011 wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone classic master controls.
REQ-012 wb_adr_o  out  32  byte address; wb_dat_o  out  DATA_SIZE  write data; wb_sel_o  out  4  byte enables.
REQ-013 wb_ack_i  in  1  slave acknowledge.
REQ-014 frame_done  out  1  one-cycle pulse after the last word of a frame is acked.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT1, WAIT2, WRITE.
REQ-016 IDLE: if en & nb_pack_available, assert wb_cyc_o and go to WAIT2; else stay.
REQ-017 WAIT2: load wb_dat_o from fifo_data on the exit edge, then go to WRITE.
REQ-018 WRITE: assert wb_stb_o and hold wb_adr_o/wb_dat_o stable until wb_ack_i.
REQ-019 r_ack SHALL be combinational, equal to (state==WRITE) & wb_ack_i.
REQ-020 On ack, if burst count < NB_PACK-1: go to WAIT1; else deassert wb_cyc_o and go to IDLE.
REQ-021 WAIT1 SHALL last exactly one cycle, then go to WAIT2; this absorbs the FIFO pointer-plus-RAM read latency, so the data is valid two cycles after r_ack.
REQ-022 wb_cyc_o SHALL stay high continuously from IDLE exit until the 16th ack of a burst.
REQ-023 wb_we_o SHALL equal wb_cyc_o; wb_sel_o SHALL be 4'hF whenever wb_stb_o is high.
REQ-024 wb_adr_o SHALL equal frame_base_latched + 4*word_idx, with word_idx in 0..FRAME_WORDS-1 of width $clog2(FRAME_WORDS).
REQ-025 frame_base SHALL be latched only when leaving IDLE with word_idx==0; changes mid-frame SHALL be ignored.
REQ-026 On the ack of word_idx==FRAME_WORDS-1, word_idx SHALL wrap to 0 and frame_done SHALL pulse for 1 cycle on the following cycle.
REQ-027 Deasserting en mid-burst SHALL NOT abort the burst; the burst completes, then the FSM stays in IDLE.
REQ-028 The FSM SHALL not leave IDLE while nb_pack_available is low; a burst never underflows the FIFO.
REQ-029 Stall: wb_ack_i low SHALL hold WRITE indefinitely with all outputs stable and r_ack low.

Reset
REQ-030 nRST low SHALL immediately force state=IDLE, wb_cyc_o=wb_stb_o=wb_we_o=0, r_ack=0, frame_done=0, wb_sel_o=0, wb_adr_o=0, wb_dat_o=0, word_idx=0, burst count=0, frame_base_latched=0.
REQ-031 Reset mid-burst SHALL abandon the burst; the FIFO is reset by the same nRST, so no resynchronisation is needed.

Structure
REQ-032 Package video_in_pkg SHALL hold DATA_SIZE, NB_PACK, FRAME_WORDS and the FSM state enum, shared with the FIFO.
REQ-033 The block SHALL be a single module with no sub-modules; the address counter and burst counter SHALL be inline registers.

Verification
REQ-034 Reset, fill FIFO model with 16 words 0..15, en=1, zero-wait slave -> 16 writes to base..base+60, data 0..15, cyc high throughout, 16 r_ack pulses, 3 cycles per word after the first.
REQ-035 Slave inserts 5 wait cycles on word 3 -> stb, addr and data held 5 cycles; exactly one r_ack for word 3.
REQ-036 FRAME_WORDS=32, base=0x1000, 2 packs -> last address 0x107C; frame_done pulses once; next burst starts at 0x1000.
REQ-037 en dropped on word 7 of a burst -> words 8..15 still written; no new burst while en=0 despite nb_pack_available=1.
REQ-038 nRST asserted in WRITE -> cyc, stb and r_ack low in the same cycle; after release the first write goes to the new base with word_idx 0.
REQ-039 frame_base changed mid-frame -> addresses continue from the old base until the frame wraps.
